// File: rtl/pulse_cell_pkg.sv
// Shared definitions for the clocked pulse-cell models (merge and distribute sides).
package pulse_cell_pkg;

  // Routing mode of the distributor, sampled only when an event is accepted.
  typedef enum logic {
    MODE_BCAST = 1'b0,
    MODE_ALT   = 1'b1
  } mode_e;

  // Default timing shared with the merge-side models.
  localparam int DEF_DELAY   = 8;
  localparam int DEF_PULSE_W = 2;
  localparam int DEF_MIN_GAP = 5;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_bits(input int max_val);
    int b;
    b = $clog2(max_val + 1);
    return (b < 1) ? 1 : b;
  endfunction

endpackage

// File: rtl/pulse_shaper.sv
// Delays a single-cycle launch strobe by DELAY cycles and stretches it to
// PULSE_W cycles. The delay line is one bit per cycle, so every launch in
// flight is tracked regardless of how many overlap inside the delay window.
module pulse_shaper
  import pulse_cell_pkg::*;
#(
  parameter int DELAY   = DEF_DELAY,
  parameter int PULSE_W = DEF_PULSE_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic launch_i,
  output logic pulse_o,
  output logic in_flight_o
);

  localparam int WW = cnt_bits(PULSE_W);

  logic [DELAY-1:0] dly_q, dly_d;
  logic [WW-1:0]    wid_q, wid_d;

  // Delay line: bit k set means a launch happened k+1 edges ago.
  always_comb begin
    dly_d    = '0;
    dly_d[0] = launch_i;
    for (int i = 1; i < DELAY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  // Width generator: a strobe leaving the delay line loads the width count.
  always_comb begin
    wid_d = wid_q;
    if (dly_q[DELAY-1]) begin
      wid_d = WW'(PULSE_W);
    end else if (wid_q != '0) begin
      wid_d = wid_q - WW'(1);
    end
  end

  // State registers; reset drops the output at once and flushes the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= '0;
      wid_q <= '0;
    end else begin
      dly_q <= dly_d;
      wid_q <= wid_d;
    end
  end

  assign pulse_o     = (wid_q != '0);
  assign in_flight_o = (|dly_q) | pulse_o;

endmodule

// File: rtl/pulse_distributor.sv
// Re-issues each accepted pulse of a merged stream on output A, B or both,
// with fixed latency and width. Edges closer than MIN_GAP to the previous
// accepted edge are dropped and counted (saturating).
module pulse_distributor
  import pulse_cell_pkg::*;
#(
  parameter int DELAY   = DEF_DELAY,
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int MIN_GAP = DEF_MIN_GAP,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             mode,
  output logic             douta,
  output logic             doutb,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  localparam int GW = cnt_bits(MIN_GAP);

  // Parameter sanity: pulses on one output must never merge.
  if (DELAY < 1) begin : g_bad_delay
    $error("pulse_distributor: DELAY must be >= 1");
  end
  if (PULSE_W < 1) begin : g_bad_width
    $error("pulse_distributor: PULSE_W must be >= 1");
  end
  if (MIN_GAP <= PULSE_W) begin : g_bad_gap
    $error("pulse_distributor: MIN_GAP must be greater than PULSE_W");
  end

  logic             din_q, din_prev_q;
  logic [GW-1:0]    gap_q, gap_d, gap_now;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             event_w, accept, reject;
  logic             launch_a, launch_b;
  logic             flight_a, flight_b;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);
  assign event_w  = din_q & ~din_prev_q;

  // gap_now is the counter as it stands in the current cycle: the registered
  // value advanced by one, saturated. That makes edges exactly MIN_GAP apart
  // acceptable and gives one accept every MIN_GAP cycles.
  always_comb begin
    gap_now = (gap_q == GW'(MIN_GAP)) ? gap_q : gap_q + GW'(1);
    accept  = event_w && (gap_now == GW'(MIN_GAP));
    reject  = event_w && !accept;
    gap_d   = accept ? '0 : gap_now;
  end

  // Routing: broadcast launches both, alternate launches the pointed output.
  always_comb begin
    launch_a = 1'b0;
    launch_b = 1'b0;
    ptr_d    = ptr_q;
    if (accept) begin
      if (mode_sel == MODE_BCAST) begin
        launch_a = 1'b1;
        launch_b = 1'b1;
      end else begin
        launch_a = ~ptr_q;
        launch_b = ptr_q;
        ptr_d    = ~ptr_q;
      end
    end
  end

  // Drop counter saturates at all-ones.
  always_comb begin
    drop_d = drop_q;
    if (reject && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  // Input sampling, gap counter, pointer and drop counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q      <= 1'b0;
      din_prev_q <= 1'b0;
      gap_q      <= GW'(MIN_GAP);
      ptr_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      din_q      <= din;
      din_prev_q <= din_q;
      gap_q      <= gap_d;
      ptr_q      <= ptr_d;
      drop_q     <= drop_d;
    end
  end

  pulse_shaper #(.DELAY(DELAY), .PULSE_W(PULSE_W)) u_shaper_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .launch_i    (launch_a),
    .pulse_o     (douta),
    .in_flight_o (flight_a)
  );

  pulse_shaper #(.DELAY(DELAY), .PULSE_W(PULSE_W)) u_shaper_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .launch_i    (launch_b),
    .pulse_o     (doutb),
    .in_flight_o (flight_b)
  );

  assign drop_cnt = drop_q;
  assign busy     = flight_a | flight_b;

endmodule

// File: tb/tb_pulse_distributor.sv
// Directed bench for pulse_distributor. Inputs change and outputs are sampled
// 1 time unit after a rising edge; "cycle c" means just after edge c of a test.
// A din set in cycle c is sampled at edge c+1 and its event decided at c+2.
module tb_pulse_distributor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic        mode;
  logic        douta, doutb, busy;
  logic [15:0] drop_cnt;
  logic        douta_s, doutb_s, busy_s;
  logic [1:0]  drop_cnt_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pulse_distributor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .mode     (mode),
    .douta    (douta),
    .doutb    (doutb),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  pulse_distributor #(.CNT_W(2)) dut_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .mode     (mode),
    .douta    (douta_s),
    .doutb    (doutb_s),
    .drop_cnt (drop_cnt_s),
    .busy     (busy_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after an edge with reset released (cycle 0).
  task automatic do_reset();
    din   = 1'b0;
    mode  = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    din   = 1'b0;
    mode  = 1'b0;
    rst_n = 1'b0;
    #3;
    total++;
    if ({douta, doutb, busy} !== 3'b000 || drop_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_async: a=%b b=%b busy=%b drop=%0d want 0 0 0 0", douta, doutb, busy, drop_cnt);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({douta, doutb, busy} !== 3'b000 || drop_cnt !== 16'd0 || drop_cnt_s !== 2'd0) begin
      bad++;
      $display("FAIL reset_idle: a=%b b=%b busy=%b drop=%0d drop_s=%0d want all 0", douta, doutb, busy, drop_cnt, drop_cnt_s);
    end
  endtask

  // Broadcast: din set in cycle 8 -> accept at edge 10 -> both high 18..19.
  task automatic test_broadcast();
    logic ea, eb;
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      din = (c == 8);
      ea  = (c >= 18 && c <= 19);
      eb  = (c >= 10 && c <= 19);
      total++;
      if (douta !== ea || doutb !== ea) begin
        bad++;
        $display("FAIL bcast_out c=%0d: a=%b b=%b want %b", c, douta, doutb, ea);
      end
      total++;
      if (busy !== eb) begin
        bad++;
        $display("FAIL bcast_busy c=%0d: busy=%b want %b", c, busy, eb);
      end
      tick();
    end
    total++;
    if (drop_cnt !== 16'd0) begin
      bad++;
      $display("FAIL bcast_drop: drop=%0d want 0", drop_cnt);
    end
  endtask

  // Alternate: accepts at 2,8,14,20,26 -> A,B,A,B,A; the fifth shows the
  // pointer returned to A after four pulses.
  task automatic test_alternate();
    logic ea, eb;
    do_reset();
    mode = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      din = (c == 0 || c == 6 || c == 12 || c == 18 || c == 24);
      ea  = (c == 10 || c == 11 || c == 22 || c == 23 || c == 34 || c == 35);
      eb  = (c == 16 || c == 17 || c == 28 || c == 29);
      total++;
      if (douta !== ea || doutb !== eb) begin
        bad++;
        $display("FAIL alt_out c=%0d: a=%b b=%b want %b %b", c, douta, doutb, ea, eb);
      end
      tick();
    end
    total++;
    if (drop_cnt !== 16'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL alt_end: drop=%0d busy=%b want 0 0", drop_cnt, busy);
    end
    mode = 1'b0;
  endtask

  // Collision: edges decided at 2 (accept), 5 (gap 3, reject), 7 (gap 5, accept).
  task automatic test_collision();
    logic ea;
    logic [15:0] ed;
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      din = (c == 0 || c == 3 || c == 5);
      ea  = (c == 10 || c == 11 || c == 15 || c == 16);
      ed  = (c >= 5) ? 16'd1 : 16'd0;
      total++;
      if (douta !== ea || doutb !== ea) begin
        bad++;
        $display("FAIL coll_out c=%0d: a=%b b=%b want %b", c, douta, doutb, ea);
      end
      total++;
      if (drop_cnt !== ed) begin
        bad++;
        $display("FAIL coll_drop c=%0d: drop=%0d want %0d", c, drop_cnt, ed);
      end
      tick();
    end
  endtask

  // Edges every 2 cycles: accepts at 2,8,14; rejects at 4,6,10,12,16.
  task automatic test_saturation();
    logic ea, eb;
    logic [15:0] ed;
    logic [1:0]  es;
    int rej;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      din = (c <= 14) && (c % 2 == 0);
      ea  = (c == 10 || c == 11 || c == 16 || c == 17 || c == 22 || c == 23);
      eb  = (c >= 2 && c <= 23);
      rej = int'(c >= 4) + int'(c >= 6) + int'(c >= 10) + int'(c >= 12) + int'(c >= 16);
      ed  = 16'(rej);
      es  = (rej > 3) ? 2'd3 : 2'(rej);
      total++;
      if (drop_cnt !== ed || drop_cnt_s !== es) begin
        bad++;
        $display("FAIL sat_drop c=%0d: drop=%0d drop_s=%0d want %0d %0d", c, drop_cnt, drop_cnt_s, ed, es);
      end
      total++;
      if (douta_s !== ea || doutb_s !== ea || busy_s !== eb || douta !== ea) begin
        bad++;
        $display("FAIL sat_out c=%0d: a=%b a_s=%b b_s=%b busy_s=%b want %b %b %b %b", c, douta, douta_s, doutb_s, busy_s, ea, ea, ea, eb);
      end
      tick();
    end
  endtask

  // Reset while A is high with B in flight and pointer at B.
  task automatic test_reset_mid();
    logic ea;
    do_reset();
    mode = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      din = (c == 0 || c == 2 || c == 6);
      if (c < 10) tick();
    end
    total++;
    if (douta !== 1'b1 || doutb !== 1'b0 || drop_cnt !== 16'd1) begin
      bad++;
      $display("FAIL mid_pre: a=%b b=%b drop=%0d want 1 0 1", douta, doutb, drop_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({douta, doutb, busy} !== 3'b000 || drop_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mid_async: a=%b b=%b busy=%b drop=%0d want 0 0 0 0", douta, doutb, busy, drop_cnt);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      din = 1'b0;
      total++;
      if ({douta, doutb, busy} !== 3'b000) begin
        bad++;
        $display("FAIL mid_flush c=%0d: a=%b b=%b busy=%b want 0 0 0", c, douta, doutb, busy);
      end
      tick();
    end
    for (int c = 0; c <= 14; c++) begin
      din = (c == 0);
      ea  = (c == 10 || c == 11);
      total++;
      if (douta !== ea || doutb !== 1'b0) begin
        bad++;
        $display("FAIL mid_after c=%0d: a=%b b=%b want %b 0", c, douta, doutb, ea);
      end
      tick();
    end
    mode = 1'b0;
  endtask

  // din held high 20 cycles in broadcast, mode flipped while in flight.
  task automatic test_held_high();
    logic ea, eb;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      din  = (c < 20);
      mode = (c >= 4);
      ea   = (c == 10 || c == 11);
      eb   = (c >= 2 && c <= 11);
      total++;
      if (douta !== ea || doutb !== ea) begin
        bad++;
        $display("FAIL held_out c=%0d: a=%b b=%b want %b", c, douta, doutb, ea);
      end
      total++;
      if (busy !== eb) begin
        bad++;
        $display("FAIL held_busy c=%0d: busy=%b want %b", c, busy, eb);
      end
      tick();
    end
    total++;
    if (drop_cnt !== 16'd0) begin
      bad++;
      $display("FAIL held_drop: drop=%0d want 0", drop_cnt);
    end
    mode = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    din   = 1'b0;
    mode  = 1'b0;
    #2;
    test_reset();
    test_broadcast();
    test_alternate();
    test_collision();
    test_saturation();
    test_reset_mid();
    test_held_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_distributor.md
Name: pulse_distributor

Overview:
Clocked distributor at the output end of a confluence-merged pulse stream: takes one pulse line and re-issues each accepted pulse on one or both of two output lines.
Fixed latency and a fixed output pulse width.
Applies the same minimum-separation rule as the merge side, so colliding pulses are dropped and counted.
Sits between a merged pulse bus and two downstream pulse consumers in the cell-level pulse models.

Parameters:
DELAY, 8, cycles from detected input edge to output rise (>=1)
PULSE_W, 2, output pulse width in cycles (>=1)
MIN_GAP, 5, minimum cycles between accepted input edges; elaboration error unless MIN_GAP > PULSE_W
CNT_W, 16, width of drop counter

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous, active-low reset
din  input  1  merged pulse stream (level, sampled on clk)
mode  input  1  0 = broadcast to both outputs, 1 = alternate A/B
douta  output  1  pulse output A
doutb  output  1  pulse output B
drop_cnt  output  CNT_W  count of rejected input edges
busy  output  1  any pulse in flight or any output high

Behaviour:
- Reset (rst_n low, asynchronous): douta=0, doutb=0, drop_cnt=0, busy=0.
  - All in-flight pulses are discarded.
  - Alternate pointer = A; gap counter = MIN_GAP (saturated).
  - Outputs fall immediately on reset assertion, mid-pulse or not.
- Edge detect: din is registered each cycle. An event occurs when the sample is 1 and the previous sample was 0. A level held high is one event.
- Gap counter: saturating counter.
  - Cleared to 0 on an accepted event.
  - Increments every cycle otherwise, saturating at MIN_GAP.
- Acceptance: the event is accepted iff the gap counter == MIN_GAP at that cycle. The first event after reset is always accepted.
- Rejection: a rejected event does not reset the gap counter. drop_cnt increments by 1 and saturates at all-ones (no wrap).
- Routing at the accept cycle (mode sampled only then):
  - mode=0: both outputs launch.
  - mode=1: the output selected by the pointer launches, then the pointer toggles.
  - A mode change affects only later events; pulses already in flight are unchanged, and the pointer is kept across mode changes.
- Timing: let edge E be the clk edge at which the event is accepted.
  - The launched output goes high at edge E+DELAY and stays high for exactly PULSE_W cycles.
  - It falls at edge E+DELAY+PULSE_W.
- Overlap: MIN_GAP > PULSE_W guarantees pulses on one output never merge. Each output still needs up to ceil(DELAY/MIN_GAP)+1 pulses tracked in flight.
- busy: 1 from the accept cycle until the last output returns low.
- Pipelined throughput: one accepted event every MIN_GAP cycles, sustained indefinitely.

Decomposition:
- Shared package pulse_cell_pkg:
  - mode enum MODE_BCAST=0, MODE_ALT=1
  - default timing constants DEF_DELAY, DEF_PULSE_W, DEF_MIN_GAP, shared with the merge-side clocked models
- Sub-module pulse_shaper, instantiated twice (A, B):
  - input launch strobe
  - DELAY-deep shift register feeding a PULSE_W width generator
  - outputs the pulse and an in-flight flag
- Top level holds edge detect, gap counter, acceptance, pointer and drop counter.

Test Plan:
- Reset, then mode=0, single din pulse accepted at edge 10 -> douta and doutb high on edges 18-19, low at 20; drop_cnt=0; busy high edges 10-19.
- mode=1, four din pulses spaced 6 cycles apart -> outputs follow A,B,A,B, each at accept+8 for 2 cycles; pointer back at A; drop_cnt=0.
- Collision: din edges at cycles 0 and 3 (gap 3 < 5) -> only the first pulse appears, drop_cnt=1. A third edge at cycle 5 is accepted (gap counted from cycle 0).
- Saturation: CNT_W=2, five rejected edges -> drop_cnt stays at 3.
- Reset mid-operation: assert rst_n low while douta is high -> douta/doutb fall without a clock edge; no pulse appears after release; next din edge is accepted and routed to A in mode=1.
- din held high 20 cycles, then mode toggled while a pulse is in flight -> exactly one output pulse, routed per mode at the accept cycle; busy returns low at accept+10.
